// File: rtl/shift_add_multiplier.sv
// Unsigned sequential shift-and-add multiplier: one CLA add and one right shift per clock,
// with a start/ready/done handshake. Includes the carry-lookahead adder it is built around.

module nBitCarryLookAheadAdder #(
  parameter int NUMBITS = 8
) (
  input  logic [NUMBITS-1:0] a_in,
  input  logic [NUMBITS-1:0] b_in,
  input  logic               c_in,
  output logic [NUMBITS-1:0] s_out,
  output logic               c_out
);
  localparam int NBLK = NUMBITS / 4;

  if (NUMBITS % 4 != 0) begin : g_bad_width
    $error("nBitCarryLookAheadAdder: NUMBITS must be a multiple of 4");
  end

  logic [NBLK:0] w_c;
  assign w_c[0] = c_in;

  // 4-bit lookahead groups, rippled between groups
  for (genvar g = 0; g < NBLK; g++) begin : g_blk
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_cc;
    assign w_g     = a_in[4*g +: 4] & b_in[4*g +: 4];
    assign w_p     = a_in[4*g +: 4] ^ b_in[4*g +: 4];
    assign w_cc[0] = w_c[g];
    assign w_cc[1] = w_g[0] | (w_p[0] & w_cc[0]);
    assign w_cc[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_cc[0]);
    assign w_cc[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                   | (w_p[2] & w_p[1] & w_p[0] & w_cc[0]);
    assign w_cc[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                   | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                   | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_cc[0]);
    assign s_out[4*g +: 4] = w_p ^ w_cc[3:0];
    assign w_c[g+1]        = w_cc[4];
  end

  assign c_out = w_c[NBLK];
endmodule

module shift_add_multiplier #(
  parameter int NUMBITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_in,
  input  logic [NUMBITS-1:0]   a_in,
  input  logic [NUMBITS-1:0]   b_in,
  output logic                 ready_out,
  output logic                 done_out,
  output logic [2*NUMBITS-1:0] p_out
);
  // state | meaning
  // IDLE  | waiting for start_in, ready_out high
  // RUN   | one shift-and-add step per cycle, NUMBITS steps
  // DONE  | done_out pulse cycle, start_in ignored
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int              CW   = $clog2(NUMBITS) + 1;
  localparam logic [CW-1:0]   LAST = CW'(NUMBITS - 1);

  if (NUMBITS % 4 != 0) begin : g_bad_width
    $error("shift_add_multiplier: NUMBITS must be a multiple of 4");
  end

  state_t              r_state;
  state_t              w_next;
  logic [NUMBITS-1:0]  r_a;
  logic [NUMBITS-1:0]  r_hi;
  logic [NUMBITS-1:0]  r_lo;
  logic [CW-1:0]       r_cnt;
  logic [NUMBITS-1:0]  w_addend;
  logic [NUMBITS-1:0]  w_s;
  logic                w_co;
  logic                w_last;

  assign w_addend = r_a & {NUMBITS{r_lo[0]}};
  assign w_last   = (r_cnt == LAST);

  nBitCarryLookAheadAdder #(NUMBITS) u_cla (
    .a_in  (r_hi),
    .b_in  (w_addend),
    .c_in  (1'b0),
    .s_out (w_s),
    .c_out (w_co)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start_in) w_next = RUN;
      RUN:     if (w_last)   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    ready_out = (r_state == IDLE);
  end

  // The carry out of each add becomes the new MSB, so the shift never loses a bit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      p_out    <= '0;
      done_out <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_in) begin
            r_a   <= a_in;
            r_hi  <= '0;
            r_lo  <= b_in;
            r_cnt <= '0;
          end
        end
        RUN: begin
          {r_hi, r_lo} <= {w_co, w_s, r_lo[NUMBITS-1:1]};
          r_cnt        <= r_cnt + CW'(1);
          if (w_last) begin
            p_out    <= {w_co, w_s, r_lo[NUMBITS-1:1]};
            done_out <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier (8- and 16-bit instances); stimulus pushes hand-computed
// results and completion cycles into queues, monitors pop and compare on every done_out pulse.
module tb_shift_add_multiplier;
  typedef struct {
    logic [31:0] p;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start8 = 1'b0;
  logic        start16 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        ready8, done8, ready16, done16;
  logic [15:0] p8;
  logic [31:0] p16;
  logic [15:0] last8;
  logic [31:0] last16;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q8[$];
  exp_t q16[$];

  shift_add_multiplier #(.NUMBITS(8)) dut8 (
    .clk(clk), .reset(reset), .start_in(start8), .a_in(a8), .b_in(b8),
    .ready_out(ready8), .done_out(done8), .p_out(p8)
  );

  shift_add_multiplier #(.NUMBITS(16)) dut16 (
    .clk(clk), .reset(reset), .start_in(start16), .a_in(a16), .b_in(b16),
    .ready_out(ready16), .done_out(done16), .p_out(p16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin : mon8
    logic rst_s;
    exp_t e;
    rst_s = reset;
    #1;
    if (done8) begin
      if (q8.size() == 0) chk("done8_unexpected", {63'b0, done8}, 64'd0);
      else begin
        e = q8.pop_front();
        chk("p8_result", p8, e.p);
        chk("done8_cycle", cyc, e.cyc);
      end
    end else if (rst_s) chk("p8_reset", p8, 64'd0);
    else chk("p8_hold", p8, last8);
    last8 = p8;
  end

  always @(posedge clk) begin : mon16
    logic rst_s;
    exp_t e;
    rst_s = reset;
    #1;
    if (done16) begin
      if (q16.size() == 0) chk("done16_unexpected", {63'b0, done16}, 64'd0);
      else begin
        e = q16.pop_front();
        chk("p16_result", p16, e.p);
        chk("done16_cycle", cyc, e.cyc);
      end
    end else if (rst_s) chk("p16_reset", p16, 64'd0);
    else chk("p16_hold", p16, last16);
    last16 = p16;
  end

  // Called at a negedge; leaves the bench at the negedge after acceptance (or after ready returns).
  task automatic issue(input bit wide, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp_p, input bit measure);
    int   n = 0;
    int   nb;
    exp_t e;
    nb = wide ? 16 : 8;
    while (!(wide ? ready16 : ready8) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_start", {63'b0, (wide ? ready16 : ready8)}, 64'd1);
    e.p   = exp_p;
    e.cyc = cyc + 1 + nb;
    if (wide) begin
      a16 = a; b16 = b; start16 = 1'b1; q16.push_back(e);
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1; q8.push_back(e);
    end
    @(negedge clk);
    start8 = 1'b0; start16 = 1'b0;
    a8 = 8'hA5; b8 = 8'h5A; a16 = 16'hDEAD; b16 = 16'hBEEF;
    if (measure) begin
      n = 0;
      while (!(wide ? ready16 : ready8) && n < 100) begin
        n++;
        @(negedge clk);
      end
      chk(wide ? "ready16_low_cycles" : "ready8_low_cycles", n, nb + 1);
      chk(wide ? "q16_drained" : "q8_drained", wide ? q16.size() : q8.size(), 64'd0);
    end
  endtask

  initial begin : stim
    int   k;
    int   n;
    exp_t e;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_ready8", {63'b0, ready8}, 64'd1);
    chk("reset_done8", {63'b0, done8}, 64'd0);
    chk("reset_p8", p8, 64'd0);
    chk("reset_ready16", {63'b0, ready16}, 64'd1);
    chk("reset_done16", {63'b0, done16}, 64'd0);
    chk("reset_p16", p16, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(1'b0, 16'd3, 16'd5, 32'd15, 1'b1);
    issue(1'b0, 16'd255, 16'd255, 32'd65025, 1'b1);
    issue(1'b0, 16'd0, 16'd200, 32'd0, 1'b1);
    issue(1'b0, 16'd200, 16'd0, 32'd0, 1'b1);

    // start held high: 7*9 then 12*12, second acceptance 10 cycles after the first
    a8 = 8'd7; b8 = 8'd9; start8 = 1'b1;
    k = cyc + 1;
    e.p = 32'd63; e.cyc = k + 8; q8.push_back(e);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i < 7) begin
        start8 = (i % 2) == 0;
        a8 = 8'hFF - 8'(i); b8 = 8'(i * 17);
      end else begin
        start8 = 1'b1; a8 = 8'd12; b8 = 8'd12;
      end
      if (i == 8) chk("held_ready_in_done", {63'b0, ready8}, 64'd0);
      if (i == 9) begin
        chk("held_ready_idle", {63'b0, ready8}, 64'd1);
        e.p = 32'd144; e.cyc = k + 18; q8.push_back(e);
      end
    end
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (!ready8 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("held_q8_drained", q8.size(), 64'd0);

    // reset 4 cycles after acceptance aborts the operation
    issue(1'b0, 16'd100, 16'd100, 32'd10000, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    q8.delete();
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ready8", {63'b0, ready8}, 64'd1);
    chk("abort_done8", {63'b0, done8}, 64'd0);
    chk("abort_p8", p8, 64'd0);
    repeat (8) @(negedge clk);
    issue(1'b0, 16'd2, 16'd3, 32'd6, 1'b1);

    issue(1'b1, 16'd65535, 16'd65535, 32'hFFFE0001, 1'b1);

    repeat (3) @(negedge clk);
    chk("final_q8_empty", q8.size(), 64'd0);
    chk("final_q16_empty", q16.size(), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected under 20000", cyc);
    $fatal(1, "watchdog timeout");
  end
endmodule
